fpnew_classify_pipe: RTL and testbench
======================================

# fpnew_classify_pipe

Pipelined, multi-format, multi-lane FP classification unit implementing the CLASSIFY operation of the NONCOMP opgroup for every enabled FP format, scalar or vectorial. Produces one 10-bit classmask per lane, with optional RISC-V NaN-box checking on scalar operands. Sits in the NONCOMP slice beside the sign-injection and compare units, and uses the same valid/ready, tag and flush protocol as the other operational units.

## Interface
- Width, 64: datapath width in bits.
- FpFmtMask, 5'b11111: enabled FP formats (fmt_logic_t).
- EnableVectors, 1: vectorial operation allowed.
- NumPipeRegs, 2: register stages, 0..8.
- TagType, logic: type of the opaque tag carried alongside each transaction.
- Derived: NumLanes = max_num_lanes(Width, FpFmtMask, EnableVectors).

- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- operands_i  in  Width  packed operand; lane i occupies bits [i*fp_width(fmt) +: fp_width(fmt)].
- src_fmt_i  in  fp_format_e  operand format.
- vectorial_op_i  in  1  operate on all lanes of src_fmt_i; ignored if EnableVectors=0.
- tag_i  in  TagType  transaction tag.
- in_valid_i / in_ready_o  in/out  1  input handshake.
- flush_i  in  1  discard all in-flight transactions.
- class_o  out  NumLanes x 10  per-lane classmask (classmask_e encoding).
- lane_mask_o  out  NumLanes  lanes carrying a valid result.
- fmt_err_o  out  1  src_fmt_i was not in FpFmtMask.
- tag_o  out  TagType  tag of the output transaction.
- out_valid_o / out_ready_i  out/in  1  output handshake.
- busy_o  out  1  at least one stage holds a valid transaction.

## Operation
- Classification is combinational at the input; its result is registered through NumPipeRegs stages.
- Per lane: E = exp_bits(fmt) bits and M = man_bits(fmt) bits, sign at the MSB. Classification rules:
  - E all-ones, M=0: NEG/POSINF.
  - E all-ones, M≠0: QNAN if M MSB=1, else SNAN.
  - E=0, M=0: NEG/POSZERO.
  - E=0, M≠0: NEG/POSSUBNORM.
  - Otherwise: NEG/POSNORM.
- Exactly one bit is set per active lane.
- Active lanes:
  - Scalar: lane 0 only.
  - Vectorial: lanes i < Width/fp_width(fmt).
  - Inactive lanes output class 0 and lane_mask 0.
- Unsupported src_fmt_i: fmt_err_o=1, all class_o=0, lane_mask_o=0. The transaction still flows through the pipe.
- Transfer rules:
  - Input transfers when in_valid_i & in_ready_o.
  - Output transfers when out_valid_o & out_ready_i.
  - Stage k advances when stage k+1 is empty or advancing (bubble-collapsing).
  - in_ready_o = stage 0 empty or advancing.
- Flush: on a cycle with flush_i=1, all stage valids clear on the next edge. An input accepted in that cycle is also discarded. in_ready_o is unaffected.
- Reset: all valid bits 0. class_o, lane_mask_o, fmt_err_o and tag_o are all 0. out_valid_o=0, busy_o=0, and in_ready_o=1 from the first cycle after reset.
- Reset and flush asserted together: reset wins; the outcome is identical.

## Timing
- Latency is NumPipeRegs cycles from input transfer to out_valid_o, assuming no backpressure.
- Throughput is one transaction per cycle.
- The pipe holds up to NumPipeRegs transactions under backpressure. Order is strictly preserved.
- NumPipeRegs=0: fully combinational. out_valid_o=in_valid_i, in_ready_o=out_ready_i. flush_i has no effect.
- Outputs are stable while out_valid_o=1 and out_ready_i=0.
- Data registers load only on advance; they are not cleared on flush.

## Configuration
- FPNEW_CLASSIFY_NANBOX_EN defined:
  - Applies only to scalar operations with fp_width(fmt) < Width.
  - If bits [Width-1:fp_width(fmt)] are not all ones, lane 0 returns QNAN (10'h200), regardless of the lane payload.
- Undefined: upper bits are ignored and the low bits are classified as-is.
- Vectorial operations are never NaN-box checked.

## Structure
- Shared in fpnew_pkg:
  - Existing: fp_format_e, FP_ENCODINGS, classmask_e, fmt_logic_t, fp_width, max_num_lanes.
  - New constant: CLASSMASK_WIDTH = 10.
  - New function: lane_active(width, fmt, vec, lane).
- Sub-module fpnew_classify_lane: combinational, one per lane. Takes a lane-width slice plus format and returns a classmask. It is multi-format over the formats valid for that lane, per get_lane_formats.
- The top level holds the stage registers, handshake and flush logic.

## Test plan
Bench configuration: Width=64, mask 5'b11111, vectors on, NumPipeRegs=2.

1. Scalar FP32 normal: 64'hFFFFFFFF_3F800000 → after 2 cycles class_o[0]=10'h040, lane_mask_o=1, tag matches.
2. Scalar FP32 with bad NaN-box: 64'h00000000_3F800000 → 10'h200 with macro defined, 10'h040 without.
3. Vector FP16 input 64'h7C00_FC00_0001_7E00 → lanes 0..3 = 10'h200, 10'h020, 10'h001, 10'h080; lane_mask_o=4'b1111.
4. Vector FP8 input 64'h7D_80_00_FF_01_3C_7C_FC → lanes 0..7 = 10'h001, 10'h080, 10'h040, 10'h020, 10'h200, 10'h010, 10'h008, 10'h100.
5. Backpressure: back-to-back inputs with tags 1..6 while out_ready_i=0 for 5 cycles → in_ready_o falls after 2 accepts. After release, tags 1..6 emerge in order with none lost.
6. Flush with 2 transactions in flight plus a simultaneous input → out_valid_o=0 and busy_o=0 on the next cycle. None of the 3 tags ever appear.

Source files
------------

// File: rtl/fpnew_pkg.sv
// Shared FP format definitions and helpers for the NONCOMP slice.
// Format table, classmask encoding, lane geometry functions.
package fpnew_pkg;

  localparam int unsigned NUM_FP_FORMATS = 5;
  localparam int unsigned CLASSMASK_WIDTH = 10;

  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  typedef logic [NUM_FP_FORMATS-1:0] fmt_logic_t;

  typedef struct packed {
    int unsigned exp_bits;
    int unsigned man_bits;
  } fp_encoding_t;

  localparam fp_encoding_t [0:NUM_FP_FORMATS-1] FP_ENCODINGS = '{
    '{8, 23},
    '{11, 52},
    '{5, 10},
    '{5, 2},
    '{8, 7}
  };

  typedef enum logic [CLASSMASK_WIDTH-1:0] {
    NEGINF     = 10'h001,
    NEGNORM    = 10'h002,
    NEGSUBNORM = 10'h004,
    NEGZERO    = 10'h008,
    POSZERO    = 10'h010,
    POSSUBNORM = 10'h020,
    POSNORM    = 10'h040,
    POSINF     = 10'h080,
    SNAN       = 10'h100,
    QNAN       = 10'h200
  } classmask_e;

  // Codes outside the table fall back to FP32 geometry; callers gate them.
  function automatic int unsigned fp_width(fp_format_e fmt);
    int unsigned w;
    w = 32;
    if (int'(fmt) < NUM_FP_FORMATS) begin
      w = FP_ENCODINGS[fmt].exp_bits
        + FP_ENCODINGS[fmt].man_bits + 1;
    end
    return w;
  endfunction

  function automatic int unsigned min_fp_width(fmt_logic_t cfg);
    int unsigned res;
    res = 32'hFFFF_FFFF;
    for (int f = 0; f < NUM_FP_FORMATS; f++) begin
      if (cfg[3'(f)] &&
          fp_width(fp_format_e'(3'(f))) < res) begin
        res = fp_width(fp_format_e'(3'(f)));
      end
    end
    return res;
  endfunction

  function automatic int unsigned max_fp_width(fmt_logic_t cfg);
    int unsigned res;
    res = 0;
    for (int f = 0; f < NUM_FP_FORMATS; f++) begin
      if (cfg[3'(f)] &&
          fp_width(fp_format_e'(3'(f))) > res) begin
        res = fp_width(fp_format_e'(3'(f)));
      end
    end
    return res;
  endfunction

  function automatic int unsigned max_num_lanes(
    int unsigned width,
    fmt_logic_t cfg,
    bit vec
  );
    return vec ? width / min_fp_width(cfg) : 1;
  endfunction

  function automatic fmt_logic_t get_lane_formats(
    int unsigned width,
    fmt_logic_t cfg,
    int unsigned lane
  );
    fmt_logic_t res;
    res = '0;
    for (int f = 0; f < NUM_FP_FORMATS; f++) begin
      res[3'(f)] = cfg[3'(f)] &&
        (lane < width / fp_width(fp_format_e'(3'(f))));
    end
    return res;
  endfunction

  function automatic logic fmt_enabled(
    fmt_logic_t cfg,
    fp_format_e fmt
  );
    logic hit;
    hit = 1'b0;
    for (int f = 0; f < NUM_FP_FORMATS; f++) begin
      if (cfg[3'(f)] && int'(fmt) == f) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic lane_active(
    int unsigned width,
    fp_format_e fmt,
    logic vec,
    int unsigned lane
  );
    if (vec) return lane < width / fp_width(fmt);
    return lane == 0;
  endfunction

endpackage

// File: rtl/fpnew_classify_lane.sv
// Combinational classifier for one lane, multi-format over the
// formats that fit this lane position.
module fpnew_classify_lane
  import fpnew_pkg::*;
#(
  parameter fmt_logic_t LaneFmts = '1,
  localparam int unsigned LaneWidth = max_fp_width(LaneFmts)
) (
  input  logic [LaneWidth-1:0]       operand,
  input  fp_format_e                 fmt,
  output logic [CLASSMASK_WIDTH-1:0] cls
);

  logic [NUM_FP_FORMATS-1:0][CLASSMASK_WIDTH-1:0] fmt_cls;

  for (genvar f = 0; f < NUM_FP_FORMATS; f++) begin : g_fmt
    localparam int unsigned E = FP_ENCODINGS[f].exp_bits;
    localparam int unsigned M = FP_ENCODINGS[f].man_bits;
    if (LaneFmts[f]) begin : g_on
      logic         sgn;
      logic [E-1:0] e;
      logic [M-1:0] m;
      logic [CLASSMASK_WIDTH-1:0] c;

      assign sgn = operand[E+M];
      assign e   = operand[M +: E];
      assign m   = operand[0 +: M];

      always_comb begin
        c = '0;
        unique case (1'b1)
          (&e && m == '0): c = sgn ? NEGINF : POSINF;
          (&e && m != '0): c = m[M-1] ? QNAN : SNAN;
          (e == '0 && m == '0): c = sgn ? NEGZERO : POSZERO;
          (e == '0 && m != '0):
            c = sgn ? NEGSUBNORM : POSSUBNORM;
          default: c = sgn ? NEGNORM : POSNORM;
        endcase
      end

      assign fmt_cls[f] = c;
    end else begin : g_off
      assign fmt_cls[f] = '0;
    end
  end

  always_comb begin
    cls = '0;
    for (int f = 0; f < NUM_FP_FORMATS; f++) begin
      if (LaneFmts[3'(f)] && fmt == fp_format_e'(3'(f))) begin
        cls = fmt_cls[3'(f)];
      end
    end
  end

endmodule

// File: rtl/fpnew_classify_pipe.sv
// Pipelined multi-lane FP classify unit with valid/ready and flush.
// Define FPNEW_CLASSIFY_NANBOX_EN to NaN-box check scalar operands.
module fpnew_classify_pipe
  import fpnew_pkg::*;
#(
  parameter int unsigned Width         = 64,
  parameter fmt_logic_t  FpFmtMask     = 5'b11111,
  parameter bit          EnableVectors = 1'b1,
  parameter int unsigned NumPipeRegs   = 2,
  parameter type         TagType       = logic,
  localparam int unsigned NumLanes =
    max_num_lanes(Width, FpFmtMask, EnableVectors)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [Width-1:0]    operands_i,
  input  fp_format_e          src_fmt_i,
  input  logic                vectorial_op_i,
  input  TagType              tag_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic                flush_i,
  output logic [NumLanes-1:0][CLASSMASK_WIDTH-1:0] class_o,
  output logic [NumLanes-1:0] lane_mask_o,
  output logic                fmt_err_o,
  output TagType              tag_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic                busy_o
);

  typedef struct packed {
    logic [NumLanes-1:0][CLASSMASK_WIDTH-1:0] cls;
    logic [NumLanes-1:0] mask;
    logic                err;
    TagType              tag;
  } stage_t;

  logic   vec;
  logic   fmt_ok;
  logic   box_bad;
  stage_t res;
  stage_t out_d;

  logic [NumLanes-1:0][CLASSMASK_WIDTH-1:0] cls_d;
  logic [NumLanes-1:0]                      mask_d;

  assign vec    = EnableVectors & vectorial_op_i;
  assign fmt_ok = fmt_enabled(FpFmtMask, src_fmt_i);

`ifdef FPNEW_CLASSIFY_NANBOX_EN
  logic [Width-1:0] low_ones;
  assign low_ones =
    {Width{1'b1}} >> (Width - fp_width(src_fmt_i));
  assign box_bad = !vec &&
    (fp_width(src_fmt_i) < Width) &&
    !(&(operands_i | low_ones));
`else
  assign box_bad = 1'b0;
`endif

  for (genvar i = 0; i < NumLanes; i++) begin : g_lane
    localparam fmt_logic_t LaneFmts =
      get_lane_formats(Width, FpFmtMask, i);
    localparam int unsigned LaneWidth = max_fp_width(LaneFmts);

    logic [LaneWidth-1:0]       slice;
    logic [CLASSMASK_WIDTH-1:0] lane_cls;
    logic                       active;

    assign slice = LaneWidth'(
      operands_i >> (i * fp_width(src_fmt_i)));

    fpnew_classify_lane #(
      .LaneFmts(LaneFmts)
    ) u_lane (
      .operand(slice),
      .fmt    (src_fmt_i),
      .cls    (lane_cls)
    );

    assign active = fmt_ok &&
      lane_active(Width, src_fmt_i, vec, i);
    assign mask_d[i] = active;
    // A broken NaN-box reads as the canonical quiet NaN.
    assign cls_d[i] = !active ? '0 :
      (i == 0 && box_bad) ? QNAN : lane_cls;
  end

  assign res.cls  = cls_d;
  assign res.mask = mask_d;
  assign res.err  = !fmt_ok;
  assign res.tag  = tag_i;

  if (NumPipeRegs == 0) begin : g_comb
    assign out_d       = res;
    assign out_valid_o = in_valid_i;
    assign in_ready_o  = out_ready_i;
    assign busy_o      = 1'b0;
  end else begin : g_pipe
    localparam int unsigned N = NumPipeRegs;

    logic [N-1:0] valid_q;
    logic [N-1:0] rdy;
    logic [N-1:0] in_v;
    stage_t       data_q [N];
    stage_t       in_d   [N];

    for (genvar k = 0; k < N; k++) begin : g_stage
      logic   v_q;
      stage_t d_q;

      if (k == 0) begin : g_head
        assign in_v[k] = in_valid_i;
        assign in_d[k] = res;
      end else begin : g_body
        assign in_v[k] = valid_q[k-1];
        assign in_d[k] = data_q[k-1];
      end

      // Ready if the exit is open or any stage from here on has a hole.
      assign rdy[k] = out_ready_i | ~(&valid_q[N-1:k]);

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          v_q <= 1'b0;
          d_q <= '0;
        end else begin
          if (flush_i)     v_q <= 1'b0;
          else if (rdy[k]) v_q <= in_v[k];
          if (rdy[k] && in_v[k]) d_q <= in_d[k];
        end
      end

      assign valid_q[k] = v_q;
      assign data_q[k]  = d_q;
    end

    assign out_d       = data_q[N-1];
    assign out_valid_o = valid_q[N-1];
    assign in_ready_o  = rdy[0];
    assign busy_o      = |valid_q;
  end

  assign class_o     = out_d.cls;
  assign lane_mask_o = out_d.mask;
  assign fmt_err_o   = out_d.err;
  assign tag_o       = out_d.tag;

endmodule

// File: tb/tb_fpnew_classify_pipe.sv
// Scoreboard bench for fpnew_classify_pipe: directed vectors plus
// randomized traffic against a field-decoding reference model.
module tb_fpnew_classify_pipe;
  import fpnew_pkg::*;

  typedef logic [7:0] tag_t;
  typedef struct packed {
    logic [7:0][9:0] cls;
    logic [7:0]      mask;
    logic            err;
    tag_t            tag;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [63:0]     operands;
  fp_format_e      src_fmt;
  logic            vectorial;
  tag_t            tag_in;
  logic            in_valid;
  logic            in_ready;
  logic            flush;
  logic [7:0][9:0] class_w;
  logic [7:0]      lane_mask;
  logic            fmt_err;
  tag_t            tag_out;
  logic            out_valid;
  logic            out_ready;
  logic            busy;

  always #5 clk = ~clk;

  fpnew_classify_pipe #(
    .Width        (64),
    .FpFmtMask    (5'b11111),
    .EnableVectors(1'b1),
    .NumPipeRegs  (2),
    .TagType      (tag_t)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .operands_i    (operands),
    .src_fmt_i     (src_fmt),
    .vectorial_op_i(vectorial),
    .tag_i         (tag_in),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .flush_i       (flush),
    .class_o       (class_w),
    .lane_mask_o   (lane_mask),
    .fmt_err_o     (fmt_err),
    .tag_o         (tag_out),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .busy_o        (busy)
  );

  exp_t exp_q[$];
  tag_t flushed[$];
  int   checks = 0;
  int   passes = 0;
  int   ready_mode = 0;

  int ebits[5] = '{8, 11, 5, 5, 8};
  int mbits[5] = '{23, 52, 10, 2, 7};

  task automatic chk(input bit ok, input string name,
                     input string act, input string req);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %s, expected %s", name, act, req);
  endtask

  function automatic logic [9:0] ref_class(
    longint unsigned v, int e_w, int m_w);
    longint unsigned s, e, m, emax;
    s    = (v >> (e_w + m_w)) & 1;
    emax = (64'd1 << e_w) - 1;
    e    = (v >> m_w) & emax;
    m    = v & ((64'd1 << m_w) - 1);
    if (e == emax) begin
      if (m == 0) return (s != 0) ? 10'h001 : 10'h080;
      return (((m >> (m_w - 1)) & 1) != 0) ? 10'h200 : 10'h100;
    end
    if (e == 0) begin
      if (m == 0) return (s != 0) ? 10'h008 : 10'h010;
      return (s != 0) ? 10'h004 : 10'h020;
    end
    return (s != 0) ? 10'h002 : 10'h040;
  endfunction

  function automatic exp_t model(logic [63:0] op, int f,
                                 bit vec, tag_t t);
    exp_t r;
    int   w, n;
    longint unsigned v;
    r = '0;
    r.tag = t;
    if (f > 4) begin
      r.err = 1'b1;
      return r;
    end
    w = ebits[f] + mbits[f] + 1;
    n = vec ? 64 / w : 1;
    for (int i = 0; i < n; i++) begin
      v = op >> (i * w);
      if (w < 64) v = v & ((64'd1 << w) - 1);
      r.cls[i]  = ref_class(v, ebits[f], mbits[f]);
      r.mask[i] = 1'b1;
    end
`ifdef FPNEW_CLASSIFY_NANBOX_EN
    if (!vec && w < 64 &&
        (op >> w) != ((64'd1 << (64 - w)) - 1))
      r.cls[0] = 10'h200;
`endif
    return r;
  endfunction

  function automatic logic [63:0] rand_op();
    logic [63:0] r;
    r = {$urandom, $urandom};
    for (int b = 0; b < 8; b++) begin
      case ($urandom_range(0, 5))
        0: r[b*8 +: 8] = 8'h00;
        1: r[b*8 +: 8] = 8'hFF;
        2: r[b*8 +: 8] = 8'h7C;
        3: r[b*8 +: 8] = 8'h80;
        default: ;
      endcase
    end
    return r;
  endfunction

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin : monitor
    exp_t act;
    exp_t e;
    bit   hit;
    if (!rst && out_valid && out_ready) begin
      act.cls  = class_w;
      act.mask = lane_mask;
      act.err  = fmt_err;
      act.tag  = tag_out;
      if (flushed.size() != 0) begin
        hit = 1'b0;
        foreach (flushed[j]) if (flushed[j] == tag_out) hit = 1'b1;
        chk(!hit, "flushed_tag", $sformatf("tag %h", tag_out),
            "no flushed tag");
      end
      if (exp_q.size() == 0) begin
        chk(1'b0, "unexpected_output",
            $sformatf("%h", act), "no output");
      end else begin
        e = exp_q.pop_front();
        chk(act === e, "output",
            $sformatf("%h", act), $sformatf("%h", e));
      end
    end
  end

  task automatic send(input logic [63:0] op, input int f,
                      input bit vec, input tag_t t,
                      input exp_t e);
    bit acc;
    acc = 1'b0;
    operands  = op;
    src_fmt   = fp_format_e'(3'(f));
    vectorial = vec;
    tag_in    = t;
    in_valid  = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        acc = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (!acc) chk(1'b0, "accept_timeout",
                  $sformatf("tag %h stuck", t), "accepted");
  endtask

  task automatic drain();
    for (int n = 0; n < 300; n++) begin
      @(posedge clk);
      if (exp_q.size() == 0) break;
    end
    #1;
    chk(exp_q.size() == 0, "drain",
        $sformatf("%0d pending", exp_q.size()), "0 pending");
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    exp_t e;
    logic [63:0] op;
    int f;
    bit vec;
    rst       = 1'b1;
    in_valid  = 1'b0;
    flush     = 1'b0;
    operands  = '0;
    src_fmt   = FP32;
    vectorial = 1'b0;
    tag_in    = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    chk(out_valid == 1'b0, "rst_out_valid",
        $sformatf("%b", out_valid), "0");
    chk(busy == 1'b0, "rst_busy", $sformatf("%b", busy), "0");
    chk(in_ready == 1'b1, "rst_in_ready",
        $sformatf("%b", in_ready), "1");
    chk(class_w == '0 && lane_mask == '0 &&
        fmt_err == 1'b0 && tag_out == '0, "rst_data",
        $sformatf("%h %h %b %h", class_w, lane_mask,
                  fmt_err, tag_out), "all zero");
    @(posedge clk);
    #1;

    e = '0; e.cls[0] = 10'h040; e.mask = 8'h01; e.tag = 8'h01;
    send(64'hFFFFFFFF_3F800000, 0, 1'b0, 8'h01, e);
    @(negedge clk);
    chk(out_valid == 1'b0, "latency_c1",
        $sformatf("%b", out_valid), "0");
    @(negedge clk);
    chk(out_valid == 1'b1, "latency_c2",
        $sformatf("%b", out_valid), "1");
    @(posedge clk);
    #1;

    e = '0; e.mask = 8'h01; e.tag = 8'h02;
`ifdef FPNEW_CLASSIFY_NANBOX_EN
    e.cls[0] = 10'h200;
`else
    e.cls[0] = 10'h040;
`endif
    send(64'h00000000_3F800000, 0, 1'b0, 8'h02, e);

    e = '0; e.mask = 8'h0F; e.tag = 8'h03;
    e.cls[0] = 10'h200; e.cls[1] = 10'h020;
    e.cls[2] = 10'h001; e.cls[3] = 10'h080;
    send(64'h7C00_FC00_0001_7E00, 2, 1'b1, 8'h03, e);

    e = '0; e.mask = 8'hFF; e.tag = 8'h04;
    e.cls[0] = 10'h001; e.cls[1] = 10'h080;
    e.cls[2] = 10'h040; e.cls[3] = 10'h020;
    e.cls[4] = 10'h200; e.cls[5] = 10'h010;
    e.cls[6] = 10'h008; e.cls[7] = 10'h100;
    send(64'h7D_80_00_FF_01_3C_7C_FC, 3, 1'b1, 8'h04, e);

    e = '0; e.mask = 8'h01; e.tag = 8'h05; e.cls[0] = 10'h001;
    send(64'hFFF0000000000000, 1, 1'b0, 8'h05, e);

    e = '0; e.err = 1'b1; e.tag = 8'h06;
    send(64'h7C00_FC00_0001_7E00, 6, 1'b1, 8'h06, e);

    e = '0; e.mask = 8'h0F; e.tag = 8'h07;
    e.cls[0] = 10'h008; e.cls[1] = 10'h020;
    e.cls[2] = 10'h001; e.cls[3] = 10'h200;
    send(64'h7FC0_FF80_0040_8000, 4, 1'b1, 8'h07, e);

    e = '0; e.mask = 8'h03; e.tag = 8'h08;
    e.cls[0] = 10'h004; e.cls[1] = 10'h100;
    send(64'h7F800001_80000001, 0, 1'b1, 8'h08, e);
    drain();

    ready_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    fork
      begin
        repeat (5) @(posedge clk);
        ready_mode = 0;
      end
    join_none
    for (int t = 1; t <= 6; t++) begin
      op = rand_op();
      send(op, 2, 1'b1, tag_t'(t), model(op, 2, 1'b1, tag_t'(t)));
      if (t == 2) begin
        @(negedge clk);
        chk(in_ready == 1'b0, "backpressure_ready",
            $sformatf("%b", in_ready), "0");
        @(posedge clk);
        #1;
      end
    end
    drain();

    ready_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    op = rand_op();
    send(op, 0, 1'b1, 8'hF0, model(op, 0, 1'b1, 8'hF0));
    send(op, 3, 1'b1, 8'hF1, model(op, 3, 1'b1, 8'hF1));
    flushed.push_back(8'hF0);
    flushed.push_back(8'hF1);
    flushed.push_back(8'hF2);
    tag_in   = 8'hF2;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(negedge clk);
    exp_q.delete();
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk(out_valid == 1'b0, "flush_out_valid",
        $sformatf("%b", out_valid), "0");
    chk(busy == 1'b0, "flush_busy", $sformatf("%b", busy), "0");
    @(posedge clk);
    #1;
    ready_mode = 0;

    ready_mode = 1;
    for (int n = 0; n < 300; n++) begin
      f   = ($urandom_range(0, 9) < 9) ? $urandom_range(0, 4)
                                       : $urandom_range(5, 7);
      vec = $urandom_range(0, 1);
      op  = rand_op();
      if (!vec && f <= 4 && $urandom_range(0, 1) == 1 &&
          ebits[f] + mbits[f] + 1 < 64)
        op = op | ~((64'd1 << (ebits[f] + mbits[f] + 1)) - 1);
      send(op, f, vec, tag_t'(8'h20 + (n % 200)),
           model(op, f, vec, tag_t'(8'h20 + (n % 200))));
    end
    ready_mode = 0;
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
